// File: rtl/logic32_pkg.sv
// Shared encodings and default widths for the iterative 32-bit logic unit.
package logic32_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SLICE_W_DEF = 8;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic32_seq_slice.sv
// Combinational SLICE_W-wide bitwise evaluator shared across all slices of a word.
module logic_slice
  import logic32_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [1:0]         op,
  output logic [SLICE_W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic32_seq.sv
// Iterative bitwise logic unit: one SLICE_W slice per clock, valid/ready on both sides.
// Optional zero flag output enabled by defining LOGIC_ZERO_FLAG_EN.
module logic32_seq
  import logic32_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [1:0]       op,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result
`ifdef LOGIC_ZERO_FLAG_EN
  ,
  output logic             resultZero
`endif
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [1:0]         op_q;
  logic [SLICE_W-1:0] a_slc;
  logic [SLICE_W-1:0] b_slc;
  logic [SLICE_W-1:0] y_slc;
`ifdef LOGIC_ZERO_FLAG_EN
  logic [SLICE_W-1:0] acc;
`endif

  // A single evaluator is time-shared; the counter picks which slice it sees.
  assign a_slc = a_q[int'(cnt)*SLICE_W +: SLICE_W];
  assign b_slc = b_q[int'(cnt)*SLICE_W +: SLICE_W];

  logic_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a  (a_slc),
    .b  (b_slc),
    .op (op_q),
    .y  (y_slc)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      result     <= '0;
      inReady    <= 1'b1;
      outValid   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_AND;
`ifdef LOGIC_ZERO_FLAG_EN
      acc        <= '0;
      resultZero <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (inValid) begin
            a_q     <= operandA;
            b_q     <= operandB;
            op_q    <= op;
            cnt     <= '0;
            state   <= ST_RUN;
            inReady <= 1'b0;
`ifdef LOGIC_ZERO_FLAG_EN
            acc     <= '0;
`endif
          end
        end
        ST_RUN: begin
          result[int'(cnt)*SLICE_W +: SLICE_W] <= y_slc;
`ifdef LOGIC_ZERO_FLAG_EN
          acc <= acc | y_slc;
`endif
          if (cnt == LAST) begin
            state    <= ST_DONE;
            outValid <= 1'b1;
`ifdef LOGIC_ZERO_FLAG_EN
            // Fold in the final slice here since acc only catches it next edge.
            resultZero <= ~|(acc | y_slc);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (outReady) begin
            state    <= ST_IDLE;
            outValid <= 1'b0;
            inReady  <= 1'b1;
`ifdef LOGIC_ZERO_FLAG_EN
            resultZero <= 1'b0;
`endif
          end
        end
        default: begin
          state    <= ST_IDLE;
          outValid <= 1'b0;
          inReady  <= 1'b1;
`ifdef LOGIC_ZERO_FLAG_EN
          resultZero <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic32_seq.sv
// Self-checking bench for logic32_seq: directed cases plus randomized traffic vs. a behavioural model.
module tb_logic32_seq;

  localparam int W  = 32;
  localparam int SW = 8;
  localparam int N  = W / SW;

  logic         clock    = 1'b0;
  logic         resetN   = 1'b1;
  logic         inValid  = 1'b0;
  logic         outReady = 1'b0;
  logic [W-1:0] operandA = '0;
  logic [W-1:0] operandB = '0;
  logic [1:0]   op       = 2'b00;
  logic         inReady;
  logic         outValid;
  logic [W-1:0] result;
`ifdef LOGIC_ZERO_FLAG_EN
  logic         resultZero;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: remaining busy cycles, whether a result is being offered, and its value.
  int           m_left  = 0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_res   = '0;
  logic [W-1:0] m_pend  = '0;

  always #5 clock = ~clock;

  logic32_seq #(.WIDTH(W), .SLICE_W(SW)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .inValid    (inValid),
    .inReady    (inReady),
    .operandA   (operandA),
    .operandB   (operandB),
    .op         (op),
    .outValid   (outValid),
    .outReady   (outReady),
    .result     (result)
`ifdef LOGIC_ZERO_FLAG_EN
    ,
    .resultZero (resultZero)
`endif
  );

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      m_left  = 0;
      m_valid = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1;
        m_res   = m_pend;
      end
    end else if (m_valid) begin
      if (outReady) m_valid = 1'b0;
    end else if (inValid) begin
      m_left = N;
      m_pend = ref_op(op, operandA, operandB);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("inReady", W'(inReady), W'(m_left == 0 && !m_valid));
      chk("outValid", W'(outValid), W'(m_valid));
      if (m_valid) chk("result", result, m_res);
`ifdef LOGIC_ZERO_FLAG_EN
      chk("resultZero", W'(resultZero), W'(m_valid && (m_res == '0)));
`endif
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
    int t = 0;
    while (!inReady && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) chk("issue_timeout", W'(inReady), W'(1));
    inValid  = 1'b1;
    operandA = a;
    operandB = b;
    op       = o;
    @(negedge clock);
    inValid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!outValid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    if (lat >= 40) chk("done_timeout", W'(outValid), W'(1));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] o, input logic [W-1:0] exp);
    int lat;
    outReady = 1'b1;
    issue(a, b, o);
    wait_done(lat);
    chk({name, "_latency"}, W'(lat), W'(N));
    chk({name, "_result"}, result, exp);
    @(negedge clock);
    chk({name, "_inReady_after"}, W'(inReady), W'(1));
    chk({name, "_outValid_after"}, W'(outValid), W'(0));
  endtask

  initial begin
    int lat;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #1 resetN = 1'b0;
    #3;
    chk("reset_result", result, '0);
    chk("reset_inReady", W'(inReady), W'(1));
    chk("reset_outValid", W'(outValid), W'(0));
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;
    chk_en = 1'b1;

    run_op("and", 32'hFFFF0000, 32'h0F0F0F0F, 2'b00, 32'h0F0F0000);
    run_op("or",  32'h12345678, 32'h0F0F0F0F, 2'b01, 32'h1F3F5F7F);
    run_op("xor", 32'h12345678, 32'h0F0F0F0F, 2'b10, 32'h1D3B5977);
    run_op("nor", 32'h12345678, 32'h0F0F0F0F, 2'b11, 32'hE0C0A080);

    // Backpressure: result must be held while downstream stalls.
    outReady = 1'b0;
    issue(32'h12345678, 32'h0F0F0F0F, 2'b10);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_outValid", W'(outValid), W'(1));
      chk("bp_inReady", W'(inReady), W'(0));
      chk("bp_result", result, 32'h1D3B5977);
      @(negedge clock);
    end
    outReady = 1'b1;
    @(negedge clock);
    chk("bp_release_outValid", W'(outValid), W'(0));
    chk("bp_release_inReady", W'(inReady), W'(1));

    // Input churn during RUN must not disturb the latched operation.
    issue(32'h12345678, 32'h0F0F0F0F, 2'b01);
    operandA = '0;
    operandB = '0;
    op       = 2'b00;
    inValid  = 1'b1;
    @(negedge clock);
    inValid = 1'b0;
    wait_done(lat);
    chk("churn_latency", W'(lat), W'(N - 1));
    chk("churn_result", result, 32'h1F3F5F7F);
    @(negedge clock);

    // Reset in the middle of an XOR.
    issue(32'hDEADBEEF, 32'h0F0F0F0F, 2'b10);
    @(negedge clock);
    @(negedge clock);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_outValid", W'(outValid), W'(0));
    chk("midrst_inReady", W'(inReady), W'(1));
    chk("midrst_result", result, '0);
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("midrst_no_valid", W'(outValid), W'(0));
    end

`ifdef LOGIC_ZERO_FLAG_EN
    outReady = 1'b1;
    issue(32'hAAAAAAAA, 32'h55555555, 2'b00);
    wait_done(lat);
    chk("zf_and_result", result, '0);
    chk("zf_and_zero", W'(resultZero), W'(1));
    @(negedge clock);
    chk("zf_after_zero", W'(resultZero), W'(0));
    issue(32'h80000000, 32'h80000000, 2'b00);
    wait_done(lat);
    chk("zf_msb_result", result, 32'h80000000);
    chk("zf_msb_zero", W'(resultZero), W'(0));
    @(negedge clock);
`endif

    // Randomized traffic; every cycle is checked against the model.
    for (int i = 0; i < 1500; i++) begin
      inValid  = ($urandom_range(0, 2) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      operandA = $urandom;
      operandB = ($urandom_range(0, 7) == 0) ? ~operandA : $urandom;
      op       = 2'($urandom_range(0, 3));
      @(negedge clock);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (N + 3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
